// File: rtl/link_pkg.sv
// Shared types for the board-to-board move link (receiver and transmitter).
package link_pkg;

    localparam int unsigned LINK_DATA_W = 2;

    // Move code carried on link_data
    typedef enum logic [1:0] {
        MV_NONE  = 2'b00,
        MV_LEFT  = 2'b01,
        MV_RIGHT = 2'b10,
        MV_PUT   = 2'b11
    } move_code_t;

    // Receiver handshake states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_SETTLE = 3'd1,
        RX_DECODE = 3'd2,
        RX_ACK    = 3'd3
    } rx_state_t;

endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer for asynchronous link inputs.
// Ports: clk, rst (async active-low), d (async input), q (synchronized output).
module link_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/move_link_rx.sv
// Receive end of the two-board move link: synchronizes req/data, waits for
// the data to settle, decodes one move per four-phase req/ack frame.
// Ports: clk, rst (async active-low), link_req/link_data (async remote inputs),
// remote_turn (turn owner), link_ack (handshake), left/right/put_pulse (one-cycle
// moves), move_rejected, frame_error (one-cycle), busy (not idle).
module move_link_rx
    import link_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_req,
    input  logic [LINK_DATA_W-1:0] link_data,
    input  logic                   remote_turn,
    output logic                   link_ack,
    output logic                   left_pulse,
    output logic                   right_pulse,
    output logic                   put_pulse,
    output logic                   move_rejected,
    output logic                   frame_error,
    output logic                   busy
);

    logic                   req_s;
    logic [LINK_DATA_W-1:0] data_s;

    link_sync #(.W(1)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (link_req),
        .q   (req_s)
    );

    link_sync #(.W(LINK_DATA_W)) u_data_sync (
        .clk (clk),
        .rst (rst),
        .d   (link_data),
        .q   (data_s)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    move_code_t       code_q, code_d;
    logic             armed_q, armed_d;
    logic             ack_q, ack_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic             put_q, put_d;
    logic             rej_q, rej_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        armed_d = armed_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        put_d   = 1'b0;
        rej_d   = 1'b0;
        ferr_d  = 1'b0;

        // A low request anywhere re-arms the receiver after a timeout
        if (!req_s) begin
            armed_d = 1'b1;
        end

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (req_s && armed_q) begin
                    state_d = RX_SETTLE;
                    code_d  = move_code_t'(data_s);
                end
            end
            RX_SETTLE: begin
                if (!req_s) begin
                    ferr_d  = 1'b1;
                    state_d = RX_IDLE;
                end else if (data_s != code_q) begin
                    code_d = move_code_t'(data_s);
                    cnt_d  = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    // Decision taken on the edge entering DECODE so the
                    // registered pulse is high exactly during DECODE.
                    state_d = RX_DECODE;
                    case (code_q)
                        MV_NONE:  ferr_d = 1'b1;
                        MV_LEFT:  begin left_d  = remote_turn; rej_d = !remote_turn; end
                        MV_RIGHT: begin right_d = remote_turn; rej_d = !remote_turn; end
                        default:  begin put_d   = remote_turn; rej_d = !remote_turn; end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DECODE: begin
                state_d = RX_ACK;
                cnt_d   = '0;
            end
            RX_ACK: begin
                if (!req_s) begin
                    state_d = RX_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    ferr_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase

        ack_d  = (state_d == RX_ACK);
        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            code_q  <= MV_NONE;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            put_q   <= 1'b0;
            rej_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            left_q  <= left_d;
            right_q <= right_d;
            put_q   <= put_d;
            rej_q   <= rej_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign link_ack      = ack_q;
    assign left_pulse    = left_q;
    assign right_pulse   = right_q;
    assign put_pulse     = put_q;
    assign move_rejected = rej_q;
    assign frame_error   = ferr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_move_link_rx.sv
// Self-checking bench for move_link_rx: directed frames plus random frames,
// every cycle compared against a frame-timing reference model.
module tb_move_link_rx;

    localparam int S = 8;
    localparam int T = 200;

    logic       clk;
    logic       rst;
    logic       link_req;
    logic [1:0] link_data;
    logic       remote_turn;
    logic       link_ack;
    logic       left_pulse;
    logic       right_pulse;
    logic       put_pulse;
    logic       move_rejected;
    logic       frame_error;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    move_link_rx #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .link_req      (link_req),
        .link_data     (link_data),
        .remote_turn   (remote_turn),
        .link_ack      (link_ack),
        .left_pulse    (left_pulse),
        .right_pulse   (right_pulse),
        .put_pulse     (put_pulse),
        .move_rejected (move_rejected),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {link_ack, left_pulse, right_pulse, put_pulse, move_rejected, frame_error, busy};
    endfunction

    // Expected {ack,left,right,put,rej,ferr,busy} at sample c of a frame whose
    // req rose at sample 0, data last changed at last_chg, req dropped at rel.
    // Inputs take 2 sync cycles plus one FSM cycle to be acted on.
    function automatic logic [6:0] model(input int c, input int last_chg, input int code,
                                         input bit turn, input int rel);
        logic [6:0] v;
        int p, e;
        v = '0;
        p = last_chg + S + 3;
        if (rel + 3 <= p) begin
            if (c == rel + 3) v[1] = 1'b1;
            if (c >= 3 && c <= rel + 2) v[0] = 1'b1;
            return v;
        end
        if (c == p) begin
            if (code == 0)  v[1] = 1'b1;
            else if (!turn) v[2] = 1'b1;
            else            v[6 - code] = 1'b1;
        end
        e = (rel + 3 > p + 2) ? rel + 3 : p + 2;
        if (e <= p + T + 1) begin
            if (c >= p + 1 && c <= e - 1) v[6] = 1'b1;
            if (c >= 3 && c <= e - 1)     v[0] = 1'b1;
        end else begin
            if (c >= p + 1 && c <= p + T) v[6] = 1'b1;
            if (c == p + T + 1)           v[1] = 1'b1;
            if (c >= 3 && c <= p + T)     v[0] = 1'b1;
        end
        return v;
    endfunction

    // Drive one frame and compare every cycle against the model
    task automatic run_frame(input int first, input int code, input int tog, input bit turn,
                             input int rel, output int moves);
        int last_chg;
        logic [6:0] got, exp_v;
        last_chg = (tog > 0 && first != code) ? tog : 0;
        moves = 0;
        remote_turn = turn;
        for (int c = 0; c <= rel + 6; c++) begin
            @(negedge clk);
            got   = outs();
            exp_v = model(c, last_chg, code, turn, rel);
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL frame(first=%0d code=%0d tog=%0d turn=%0d rel=%0d) c=%0d got=%b exp=%b",
                         first, code, tog, turn, rel, c, got, exp_v);
            end
            if (left_pulse || right_pulse || put_pulse) moves++;
            if (c == 0) begin
                link_req  = 1'b1;
                link_data = 2'(first);
            end
            if (tog > 0 && c == tog) link_data = 2'(code);
            if (c == rel) link_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", outs(), 7'b0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (outs() !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_release got=%b exp=%b", outs(), 7'b0);
            end
        end
    endtask

    task automatic test_left();
        int m;
        run_frame(1, 1, 0, 1'b1, S + 10, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL left_count got=%0d exp=1", m); end
    endtask

    task automatic test_reject();
        int m;
        run_frame(3, 3, 0, 1'b0, S + 8, m);
        n_checks++;
        if (m !== 0) begin n_fail++; $display("FAIL reject_count got=%0d exp=0", m); end
    endtask

    task automatic test_toggle();
        int m;
        run_frame(2, 1, S / 2, 1'b1, S / 2 + S + 10, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL toggle_count got=%0d exp=1", m); end
        run_frame(3, 2, S - 1, 1'b1, 2 * S + 10, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL toggle_late_count got=%0d exp=1", m); end
    endtask

    task automatic test_settle_drop();
        int m;
        run_frame(1, 1, 0, 1'b1, 4, m);
        n_checks++;
        if (m !== 0) begin n_fail++; $display("FAIL drop_count got=%0d exp=0", m); end
        // Drop reaches the FSM on the same edge the count completes
        run_frame(2, 2, 0, 1'b1, S, m);
        n_checks++;
        if (m !== 0) begin n_fail++; $display("FAIL drop_edge_count got=%0d exp=0", m); end
    endtask

    task automatic test_none_code();
        int m;
        run_frame(0, 0, 0, 1'b1, S + 9, m);
        n_checks++;
        if (m !== 0) begin n_fail++; $display("FAIL none_count got=%0d exp=0", m); end
    endtask

    task automatic test_timeout();
        int m;
        run_frame(1, 1, 0, 1'b1, S + 3 + T + 20, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL timeout_count got=%0d exp=1", m); end
        // Release on the last edge before timeout: release wins
        run_frame(3, 3, 0, 1'b1, S + 3 + T - 2, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL timeout_edge_count got=%0d exp=1", m); end
    endtask

    task automatic test_reset_mid_ack();
        int m;
        @(negedge clk);
        remote_turn = 1'b1;
        link_req    = 1'b1;
        link_data   = 2'd1;
        repeat (S + 6) @(negedge clk);
        n_checks++;
        if (link_ack !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack got=%b exp=1", link_ack); end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({link_ack, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset ack/busy got=%b exp=00", {link_ack, busy});
        end
        @(negedge clk);
        link_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(2, 2, 0, 1'b1, S + 10, m);
        n_checks++;
        if (m !== 1) begin n_fail++; $display("FAIL post_reset_count got=%0d exp=1", m); end
    endtask

    task automatic test_random();
        int m, first, code, tog, rel;
        bit turn;
        for (int i = 0; i < 30; i++) begin
            code = int'($urandom_range(0, 3));
            turn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                tog   = int'($urandom_range(1, S - 1));
                first = int'($urandom_range(0, 3));
            end else begin
                tog   = 0;
                first = code;
            end
            case ($urandom_range(0, 3))
                0:       rel = int'($urandom_range(1, S));
                1:       rel = S + 3 + T + int'($urandom_range(0, 10));
                default: rel = 2 * S + 3 + int'($urandom_range(0, 30));
            endcase
            run_frame(first, code, tog, turn, rel, m);
        end
    endtask

    initial begin
        rst         = 1'b0;
        link_req    = 1'b0;
        link_data   = 2'b00;
        remote_turn = 1'b0;
        test_reset();
        test_left();
        test_reject();
        test_toggle();
        test_settle_drop();
        test_none_code();
        test_timeout();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
